// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: 6-digit multiplexed 7-segment scanner with per-frame digit snapshot,
// anti-ghost blanking, leading-zero suppression, separator dots and invalid-BCD dash.
module seg7_scan_driver #(
    parameter int SCAN_DIV       = 50000,
    parameter int BLANK_CYCLES   = 4,
    parameter int ACTIVE_LOW_SEG = 1,
    parameter int ACTIVE_LOW_AN  = 1,
    parameter int BLANK_LEADING  = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] sec_lsb,
    input  logic [3:0] sec_msb,
    input  logic [3:0] min_lsb,
    input  logic [3:0] min_msb,
    input  logic [3:0] hr_lsb,
    input  logic [3:0] hr_msb,
    output logic [6:0] seg,
    output logic       dp,
    output logic [5:0] an,
    output logic       frame_tick
);
    localparam int CW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
    localparam logic [6:0] SEG_INV = ACTIVE_LOW_SEG != 0 ? 7'h7F : 7'h00;
    localparam logic       DP_INV  = ACTIVE_LOW_SEG != 0;
    localparam logic [5:0] AN_INV  = ACTIVE_LOW_AN != 0 ? 6'h3F : 6'h00;

    logic [CW-1:0]   cnt;
    logic [2:0]      idx;
    logic [5:0][3:0] snap;
    logic            wrap, frame, active, blank_lead;
    logic [3:0]      digit;
    logic [6:0]      code, seg_n;
    logic            dp_n;
    logic [5:0]      an_n;

    always_comb begin
        wrap       = cnt == CW'(SCAN_DIV - 1);
        frame      = wrap && idx == 3'd5;
        digit      = snap[idx];
        active     = enable && cnt >= CW'(BLANK_CYCLES);
        blank_lead = BLANK_LEADING != 0 && idx == 3'd5 && snap[5] == 4'd0;
        case (digit)
            4'd0:    code = 7'h3F;
            4'd1:    code = 7'h06;
            4'd2:    code = 7'h5B;
            4'd3:    code = 7'h4F;
            4'd4:    code = 7'h66;
            4'd5:    code = 7'h6D;
            4'd6:    code = 7'h7D;
            4'd7:    code = 7'h07;
            4'd8:    code = 7'h7F;
            4'd9:    code = 7'h6F;
            default: code = 7'h40;
        endcase
        seg_n = active && !blank_lead ? code : 7'h00;
        dp_n  = active && (idx == 3'd2 || idx == 3'd4);
        an_n  = active ? 6'd1 << idx : 6'd0;
    end

    // Snapshot loads on the last cycle of digit 5 so a whole frame shows one consistent time
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt        <= '0;
            idx        <= '0;
            snap       <= '0;
            seg        <= SEG_INV;
            dp         <= DP_INV;
            an         <= AN_INV;
            frame_tick <= 1'b0;
        end else begin
            cnt        <= wrap ? '0 : cnt + 1'b1;
            idx        <= wrap ? (idx == 3'd5 ? 3'd0 : idx + 3'd1) : idx;
            snap       <= frame ? {hr_msb, hr_lsb, min_msb, min_lsb, sec_msb, sec_lsb} : snap;
            seg        <= seg_n ^ SEG_INV;
            dp         <= dp_n ^ DP_INV;
            an         <= an_n ^ AN_INV;
            frame_tick <= frame;
        end
    end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: randomized scoreboard bench; a frame-level reference model predicts
// every output cycle for an active-high and an active-low instance driven from the same inputs.
module tb_seg7_scan_driver;
    localparam int SD = 8, BC = 2, FRAME = SD * 6;

    logic clk = 1'b0, reset = 1'b1, enable = 1'b0;
    logic [3:0] d [6];
    logic [6:0] seg_h, seg_l;
    logic       dp_h, dp_l, tick_h, tick_l;
    logic [5:0] an_h, an_l;

    typedef struct packed {
        logic [6:0] seg;
        logic       dp;
        logic [5:0] an;
        logic       tick;
    } exp_t;

    exp_t exp_q [$];
    int errors = 0, checks = 0;
    int n = 0;
    int snap [6] = '{0, 0, 0, 0, 0, 0};
    logic [6:0] font [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

    seg7_scan_driver #(.SCAN_DIV(SD), .BLANK_CYCLES(BC), .ACTIVE_LOW_SEG(0),
                       .ACTIVE_LOW_AN(0), .BLANK_LEADING(1)) dut_h (
        .clk(clk), .reset(reset), .enable(enable),
        .sec_lsb(d[0]), .sec_msb(d[1]), .min_lsb(d[2]), .min_msb(d[3]), .hr_lsb(d[4]), .hr_msb(d[5]),
        .seg(seg_h), .dp(dp_h), .an(an_h), .frame_tick(tick_h));

    seg7_scan_driver #(.SCAN_DIV(SD), .BLANK_CYCLES(BC), .ACTIVE_LOW_SEG(1),
                       .ACTIVE_LOW_AN(1), .BLANK_LEADING(1)) dut_l (
        .clk(clk), .reset(reset), .enable(enable),
        .sec_lsb(d[0]), .sec_msb(d[1]), .min_lsb(d[2]), .min_msb(d[3]), .hr_lsb(d[4]), .hr_msb(d[5]),
        .seg(seg_l), .dp(dp_l), .an(an_l), .frame_tick(tick_l));

    always #5 clk = ~clk;

    // Reference: step n of the scan shows digit (n / SD) % 6 at slot offset n % SD
    always @(posedge clk) begin
        exp_t e;
        e = '0;
        if (reset) begin
            n = 0;
            snap = '{0, 0, 0, 0, 0, 0};
        end else begin
            int c, i;
            logic lit;
            c = n % SD;
            i = (n / SD) % 6;
            lit = enable && c >= BC;
            e.an   = lit ? 6'(1 << i) : 6'd0;
            e.dp   = lit && (i == 2 || i == 4);
            e.seg  = (lit && !(i == 5 && snap[5] == 0)) ? font[snap[i]] : 7'h00;
            e.tick = (c == SD - 1 && i == 5);
            if (e.tick)
                for (int k = 0; k < 6; k++) snap[k] = int'(d[k]);
            n++;
        end
        exp_q.push_back(e);
    end

    task automatic cmp(input string name, input exp_t act, input exp_t want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s t=%0t seg/dp/an/tick got %h/%b/%b/%b want %h/%b/%b/%b", name, $time,
                     act.seg, act.dp, act.an, act.tick, want.seg, want.dp, want.an, want.tick);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e, inv;
            e = exp_q.pop_front();
            inv = {~e.seg, ~e.dp, ~e.an, e.tick};
            cmp("scan_hi", {seg_h, dp_h, an_h, tick_h}, e);
            cmp("scan_lo", {seg_l, dp_l, an_l, tick_l}, inv);
        end
    end

    task automatic set_all(input int h1, h0, m1, m0, s1, s0);
        d[5] = 4'(h1); d[4] = 4'(h0); d[3] = 4'(m1); d[2] = 4'(m0); d[1] = 4'(s1); d[0] = 4'(s0);
    endtask

    task automatic run(input int cycles);
        repeat (cycles) @(negedge clk);
    endtask

    initial begin
        set_all(1, 2, 3, 4, 5, 6);
        @(negedge clk);
        #1;
        cmp("reset_hi", {seg_h, dp_h, an_h, tick_h}, {7'h00, 1'b0, 6'h00, 1'b0});
        cmp("reset_lo", {seg_l, dp_l, an_l, tick_l}, {7'h7F, 1'b1, 6'h3F, 1'b0});
        run(2);
        reset = 1'b0;
        enable = 1'b1;
        run(2 * FRAME);
        run(FRAME + 2 * SD + 3);
        set_all(9, 9, 5, 9, 2, 3);
        run(2 * FRAME);
        d[2] = 4'hC;
        run(FRAME + 5);
        enable = 1'b0;
        run(20);
        enable = 1'b1;
        run(FRAME - (FRAME + 5 + 20) % FRAME + 3 * SD + 4);
        #2;
        reset = 1'b1;
        #1;
        cmp("async_rst_hi", {seg_h, dp_h, an_h, tick_h}, {7'h00, 1'b0, 6'h00, 1'b0});
        cmp("async_rst_lo", {seg_l, dp_l, an_l, tick_l}, {7'h7F, 1'b1, 6'h3F, 1'b0});
        run(2);
        reset = 1'b0;
        run(FRAME);
        for (int t = 0; t < 1500; t++) begin
            if ($urandom_range(0, 15) == 0) d[$urandom_range(0, 5)] = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 63) == 0) d[5] = 4'd0;
            if ($urandom_range(0, 31) == 0) enable = ~enable;
            @(negedge clk);
        end
        enable = 1'b1;
        run(FRAME);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
